spi_mem_loader: RTL and testbench
=================================

Name: spi_mem_loader

Overview:
SPI slave that sits upstream of the tiny processor core and loads or reads back its instruction and data register files from the uio pins. It is clocked by the core clock and oversamples sclk, csi, csd and mosi. Each received byte becomes a single-cycle write strobe to IMEM or DMEM. In read frames it shifts addressed memory contents out on miso. While any frame is active it holds the core.

Parameters:
ADDR_W, 4, register-file address width (IMEM and DMEM)
DATA_W, 8, byte width of IMEM/DMEM entries and SPI bytes
DMEM_DEPTH, 15, valid DMEM entries; higher addresses are unmapped
SYNC_STAGES, 2, metastability flops per SPI input

Ports:
clk  in  1  core clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock, idle low (mode 0); asynchronous to clk
csi  in  1  IMEM chip select, active low
csd  in  1  DMEM chip select, active low
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out, MSB first; registered
wr_en  out  1  one-clk write strobe
wr_sel  out  1  0 = IMEM, 1 = DMEM
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
rd_sel  out  1  0 = IMEM, 1 = DMEM
rd_addr  out  ADDR_W  read address, combinational lookup by the memory side
rd_data  in  DATA_W  memory contents at rd_sel/rd_addr, valid the same cycle
cpu_hold  out  1  high while a valid frame is active; core freezes its pc and writes

Behaviour:
- Synchronization and edge detection
  - sclk, csi, csd and mosi each pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected on the synchronized signals.
  - With the defaults, a pin edge is acted on 3 clk later.
  - sclk must be at most clk/8; behaviour above that rate is not defined.
- Reset values: miso=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, rd_sel=0, rd_addr=0, cpu_hold=0, FSM=IDLE, bit counter=0.
- FSM states: IDLE, CMD, WDATA, RDATA, ERR.
  - IDLE -> CMD: exactly one synchronized CS falls low. The selected target is latched into sel, and the bit counter clears.
  - IDLE -> ERR: both CS are low.
  - CMD: shift mosi in on each synchronized sclk rise. On the 8th bit:
    - addr <= cmd[3:0].
    - cmd[7]=0 -> WDATA.
    - cmd[7]=1 -> RDATA. rd_addr = addr, and the shift-out register loads rd_data in that same cycle.
    - cmd[6:4] are ignored.
  - WDATA: shift 8 bits in. On the 8th rise, issue a one-clk write (wr_en=1 with wr_sel, wr_addr, wr_data set), then addr <= addr+1 mod 16.
  - RDATA:
    - miso = shift_reg[7] while in RDATA.
    - Shift left on each synchronized sclk fall, except the fall directly after the command byte.
    - After each 8th data-bit rise: addr <= addr+1 mod 16, then reload the shift register from rd_data at the new address on the next clk.
  - Any state except ERR -> IDLE on the active CS rising.
  - Any state -> ERR when both CS are low simultaneously.
  - ERR -> IDLE only when both CS are high.
- Boundary conditions
  - DMEM writes to addresses >= DMEM_DEPTH are suppressed (wr_en stays 0), but the address still increments.
  - DMEM reads at address >= DMEM_DEPTH shift out 8'h00.
  - Address wraps 15 -> 0 for both targets.
  - CS deasserted mid-byte: the partial byte is discarded, no write occurs, return to IDLE.
  - Clock-domain rule: a CS rise and an sclk rise detected in the same clk give priority to the CS rise.
  - Reset mid-frame: all outputs return to reset values immediately (asynchronous). After reset the FSM waits in IDLE for CS high then low again; a CS held low through reset does not start a frame.
- cpu_hold = 1 in CMD, WDATA and RDATA; 0 in IDLE and ERR.
- miso = 0 whenever the FSM is not in RDATA.
- wr_en is never asserted in ERR, CMD or RDATA.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W and DMEM_DEPTH.
  - An FSM state enumeration (IDLE, CMD, WDATA, RDATA, ERR).
  - SEL_IMEM=0 and SEL_DMEM=1.
  - CMD_READ_BIT=7.
- One sub-module is natural: spi_sync_edge, a SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instantiated for sclk, csi and csd. mosi uses the synchronizer only.

Test Plan:
- csi low, send 8'h0E, 8'hA1, 8'hB2, 8'hC3, csi high -> wr_en pulses 3 times, all with wr_sel=0: (14, A1), (15, B2), (0, C3); cpu_hold high only during the frame.
- csd low, send 8'h0E, 8'h55, 8'h66 -> one write (dmem 14, 55); no strobe for address 15; wr_addr wraps to 0 internally.
- Preload dmem[3]=8'h9C and dmem[4]=8'h21; csd low, send 8'h83, then clock 16 bits -> miso returns 9C then 21, MSB first, changing only after sclk falls.
- csi and csd both low, send 8'h00, 8'hFF -> no wr_en, cpu_hold=0, miso=0; after both go high, a normal write frame succeeds.
- csi low, send 8'h02 plus 5 bits, csi high -> no wr_en; the next frame 8'h02, 8'h7E writes (imem 2, 7E).
- Assert rst mid-WDATA byte -> all outputs 0 immediately; after rst falls, with csi still low, no writes until csi toggles high then low.

Source files
------------

// File: rtl/spi_mem_loader_pkg.sv
// Shared widths, select encodings and FSM states for the SPI memory loader.
// Latency: n/a (types and constants only); backpressure: n/a.
package spi_mem_loader_pkg;

  localparam int ADDR_W       = 4;
  localparam int DATA_W       = 8;
  localparam int DMEM_DEPTH   = 15;
  localparam int CMD_READ_BIT = 7;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    ERR
  } state_e;

  function automatic logic dmem_unmapped(input logic sel, input logic [ADDR_W-1:0] addr);
    return (sel == SEL_DMEM) && (int'(addr) >= DMEM_DEPTH);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes one asynchronous input and flags its rising/falling edges.
// Latency: SYNC_STAGES clk to q, edge pulses one clk wide; backpressure: none.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Resetting low means a chip select held low through reset never shows a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that writes/reads back IMEM and DMEM and holds the core during frames.
// Latency: pin edges act SYNC_STAGES+1 clk later; backpressure: none, sclk must stay <= clk/8.
module spi_mem_loader
  import spi_mem_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              csi,
  input  logic              csd,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cpu_hold
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csi_s, csi_rise, csi_fall;
  logic csd_s, csd_rise, csd_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csi (
    .clk(clk), .rst(rst), .d(csi), .q(csi_s), .rise(csi_rise), .fall(csi_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csd (
    .clk(clk), .rst(rst), .d(csd), .q(csd_s), .rise(csd_rise), .fall(csd_fall));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               reload_q, reload_d;
  logic               skip_fall_q, skip_fall_d;
  logic               armed_q, armed_d;
  logic               miso_q, miso_d;
  logic               wr_en_q, wr_en_d;
  logic               wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic               both_low, cs_rise, last_bit, frame_break, cmd_done;
  logic [DATA_W-1:0]  shift_in, rd_val;

  assign both_low    = armed_q && !csi_s && !csd_s;
  assign cs_rise     = (sel_q == SEL_DMEM) ? csd_rise : csi_rise;
  assign last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign shift_in    = {shift_q[DATA_W-2:0], mosi_s};
  assign frame_break = both_low || cs_rise;
  assign cmd_done    = (state_q == CMD) && !frame_break && sclk_rise && last_bit;

  // A read command addresses memory in the same clk its last bit lands, so the first byte is ready before the next rise.
  assign rd_sel  = sel_q;
  assign rd_addr = (cmd_done && shift_in[CMD_READ_BIT]) ? shift_in[ADDR_W-1:0] : addr_q;
  assign rd_val  = dmem_unmapped(sel_q, rd_addr) ? '0 : rd_data;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reload_d    = 1'b0;
    skip_fall_d = skip_fall_q;
    armed_d     = armed_q || (csi_s && csd_s);
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (both_low) begin
      state_d = ERR;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q && !sclk_s && (csi_fall ^ csd_fall)) begin
            state_d   = CMD;
            sel_d     = csd_fall ? SEL_DMEM : SEL_IMEM;
            bit_cnt_d = '0;
          end
        end
        ERR: begin
          if (csi_s && csd_s) state_d = IDLE;
        end
        CMD: begin
          if (cs_rise) begin
            state_d = IDLE;
          end else if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              addr_d = shift_in[ADDR_W-1:0];
              if (shift_in[CMD_READ_BIT]) begin
                state_d     = RDATA;
                shift_d     = rd_val;
                skip_fall_d = 1'b1;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (cs_rise) begin
            state_d = IDLE;
          end else if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              wr_en_d   = !dmem_unmapped(sel_q, addr_q);
              wr_sel_d  = sel_q;
              wr_addr_d = addr_q;
              wr_data_d = shift_in;
              addr_d    = addr_q + 1'b1;
            end
          end
        end
        RDATA: begin
          // Each freshly loaded byte keeps its MSB on miso through the following fall.
          if (cs_rise) begin
            state_d = IDLE;
          end else if (reload_q) begin
            shift_d = rd_val;
          end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit) begin
              addr_d      = addr_q + 1'b1;
              reload_d    = 1'b1;
              skip_fall_d = 1'b1;
            end
          end else if (sclk_fall) begin
            if (skip_fall_q) skip_fall_d = 1'b0;
            else             shift_d     = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end

    miso_d = (state_d == RDATA) ? shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= SEL_IMEM;
      addr_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reload_q    <= 1'b0;
      skip_fall_q <= 1'b0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= SEL_IMEM;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reload_q    <= reload_d;
      skip_fall_q <= skip_fall_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign miso     = miso_q;
  assign wr_en    = wr_en_q;
  assign wr_sel   = wr_sel_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = (state_q == CMD) || (state_q == WDATA) || (state_q == RDATA);

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed SPI frames against a frame-level model of the loader's writes, reads and hold timing.
module tb_spi_mem_loader;
  import spi_mem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst, sclk, csi, csd, mosi;
  logic miso, wr_en, wr_sel, rd_sel, cpu_hold;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       sel;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] imem[16];
  logic [7:0] dmem[16];
  logic [7:0] tx[8];
  logic [7:0] rx[8];
  logic       hold_pin = 1'b0;
  logic       rd_pin = 1'b0;
  logic       h1 = 1'b0, h2 = 1'b0, r1 = 1'b0, r2 = 1'b0;

  always #5 clk = ~clk;

  assign rd_data = rd_sel ? dmem[rd_addr] : imem[rd_addr];

  spi_mem_loader dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csi(csi), .csd(csd), .mosi(mosi),
    .miso(miso), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .cpu_hold(cpu_hold));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of mode 0: mosi changes after a fall, miso is sampled just before the rise.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      wait_clk(6);
      r = {r[6:0], miso};
      sclk = 1'b1;
      wait_clk(6);
      sclk = 1'b0;
    end
  endtask

  // Expected writes of a complete write frame held in tx[0..nb-1].
  task automatic model_frame(input logic sel, input int nb);
    logic [3:0] a;
    a = tx[0][3:0];
    if (tx[0][7] == 1'b0) begin
      for (int k = 1; k < nb; k++) begin
        if (!(sel && int'(a) >= DMEM_DEPTH)) exp_q.push_back({sel, a, tx[k]});
        a = a + 4'd1;
      end
    end
  endtask

  function automatic logic [7:0] model_rd(input logic sel, input logic [3:0] a);
    if (sel && int'(a) >= DMEM_DEPTH) return 8'h00;
    return sel ? dmem[a] : imem[a];
  endfunction

  task automatic frame(input logic use_d, input logic both, input int nb, input int tail);
    logic [7:0] dummy;
    if (both) begin
      csi = 1'b0;
      csd = 1'b0;
    end else if (use_d) begin
      csd = 1'b0;
    end else begin
      csi = 1'b0;
    end
    hold_pin = !both;
    rd_pin = !both && tx[0][7];
    wait_clk(6);
    for (int k = 0; k < nb; k++) send_bits(tx[k], 8, rx[k]);
    if (tail > 0) send_bits(tx[nb], tail, dummy);
    wait_clk(6);
    csi = 1'b1;
    csd = 1'b1;
    hold_pin = 1'b0;
    rd_pin = 1'b0;
    wait_clk(12);
  endtask

  // Per-cycle compare: hold follows the pins 2 samples later, miso idles outside read frames, writes match the model in order.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        h1 = 1'b0; h2 = 1'b0; r1 = 1'b0; r2 = 1'b0;
      end else begin
        chk("cpu_hold", 32'(cpu_hold), 32'(h2));
        if (!r2) chk("miso_idle", 32'(miso), 32'(0));
        if (wr_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_wr: got sel=%0d addr=%0d data=%0h expected no write",
                     wr_sel, wr_addr, wr_data);
          end else begin
            w = exp_q.pop_front();
            if ({wr_sel, wr_addr, wr_data} !== w) begin
              failures++;
              $display("FAIL wr: got %0h expected %0h", {wr_sel, wr_addr, wr_data}, w);
            end
          end
        end
        h2 = h1; h1 = hold_pin; r2 = r1; r1 = rd_pin;
      end
    end
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; csi = 1'b1; csd = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'h40 + 8'(i);
      dmem[i] = 8'h80 + 8'(i);
    end
    dmem[0] = 8'h5A; dmem[3] = 8'h9C; dmem[4] = 8'h21; dmem[15] = 8'hEE;

    wait_clk(3);
    #1;
    chk("rst_outputs", 32'({miso, wr_en, wr_sel, wr_addr, wr_data, rd_sel, rd_addr, cpu_hold}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_clk(10);

    // IMEM burst wrapping 15 -> 0
    tx[0] = 8'h0E; tx[1] = 8'hA1; tx[2] = 8'hB2; tx[3] = 8'hC3;
    model_frame(1'b0, 4);
    chk("t1_model_n", 32'(exp_q.size()), 32'(3));
    chk("t1_model_0", 32'(exp_q[0]), 32'({1'b0, 4'd14, 8'hA1}));
    chk("t1_model_2", 32'(exp_q[2]), 32'({1'b0, 4'd0, 8'hC3}));
    frame(1'b0, 1'b0, 4, 0);

    // DMEM write to unmapped address 15 is dropped
    tx[0] = 8'h0E; tx[1] = 8'h55; tx[2] = 8'h66;
    model_frame(1'b1, 3);
    chk("t2_model_n", 32'(exp_q.size()), 32'(1));
    chk("t2_model_0", 32'(exp_q[0]), 32'({1'b1, 4'd14, 8'h55}));
    frame(1'b1, 1'b0, 3, 0);

    // DMEM read of 3,4
    tx[0] = 8'h83; tx[1] = 8'h00; tx[2] = 8'h00;
    frame(1'b1, 1'b0, 3, 0);
    chk("t3_cmd_miso", 32'(rx[0]), 32'(0));
    chk("t3_rd0", 32'(rx[1]), 32'(model_rd(1'b1, 4'd3)));
    chk("t3_rd1", 32'(rx[2]), 32'(model_rd(1'b1, 4'd4)));
    chk("t3_rd0_lit", 32'(rx[1]), 32'(8'h9C));
    chk("t3_rd1_lit", 32'(rx[2]), 32'(8'h21));

    // DMEM read of unmapped 15 then wrap to 0
    tx[0] = 8'h8F; tx[1] = 8'h00; tx[2] = 8'h00;
    frame(1'b1, 1'b0, 3, 0);
    chk("t3b_rd15", 32'(rx[1]), 32'(model_rd(1'b1, 4'd15)));
    chk("t3b_rd15_lit", 32'(rx[1]), 32'(8'h00));
    chk("t3b_rd0", 32'(rx[2]), 32'(model_rd(1'b1, 4'd0)));

    // IMEM read
    tx[0] = 8'h87; tx[1] = 8'h00;
    frame(1'b0, 1'b0, 2, 0);
    chk("t3c_imem7", 32'(rx[1]), 32'(model_rd(1'b0, 4'd7)));

    // Both selects low: error frame, then recovery
    tx[0] = 8'h00; tx[1] = 8'hFF;
    frame(1'b0, 1'b1, 2, 0);
    tx[0] = 8'h01; tx[1] = 8'h77;
    model_frame(1'b0, 2);
    frame(1'b0, 1'b0, 2, 0);

    // Partial byte aborted, then a full frame
    tx[0] = 8'h02; tx[1] = 8'hF8;
    frame(1'b0, 1'b0, 1, 5);
    tx[0] = 8'h02; tx[1] = 8'h7E;
    model_frame(1'b0, 2);
    chk("t5_model_0", 32'(exp_q[0]), 32'({1'b0, 4'd2, 8'h7E}));
    frame(1'b0, 1'b0, 2, 0);

    // Reset in the middle of a data byte with csi still low
    csi = 1'b0;
    hold_pin = 1'b1;
    wait_clk(6);
    send_bits(8'h05, 8, rx[0]);
    send_bits(8'hA5, 3, rx[7]);
    wait_clk(3);
    chk("t6_hold_pre", 32'(cpu_hold), 32'(1));
    rst = 1'b1;
    hold_pin = 1'b0;
    #1;
    chk("t6_rst_outputs", 32'({miso, wr_en, wr_sel, wr_addr, wr_data, rd_sel, rd_addr, cpu_hold}), 32'(0));
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    send_bits(8'hA5, 5, rx[7]);
    send_bits(8'h3C, 8, rx[7]);
    wait_clk(6);
    chk("t6_hold_after", 32'(cpu_hold), 32'(0));
    csi = 1'b1;
    wait_clk(12);
    tx[0] = 8'h06; tx[1] = 8'h3C;
    model_frame(1'b0, 2);
    frame(1'b0, 1'b0, 2, 0);

    wait_clk(20);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
